// File: rtl/crc_frame_scheduler.sv
// Two-requester AXI-Stream framer: round-robin grant, payload pass-through into a shared CRC
// engine, CRC word appended with m_tlast. Define CRC_FRAME_TIMEOUT_EN to bound the CRC wait.
module crc_frame_scheduler #(
    parameter int DATA_WIDTH  = 32,
    parameter int MAX_WORDS   = 256,
    parameter int CRC_TIMEOUT = 16
) (
    input  logic                  axis_aclk,
    input  logic                  axis_aresetn,
    input  logic [DATA_WIDTH-1:0] s0_tdata,
    input  logic                  s0_tvalid,
    input  logic                  s0_tlast,
    output logic                  s0_tready,
    input  logic [DATA_WIDTH-1:0] s1_tdata,
    input  logic                  s1_tvalid,
    input  logic                  s1_tlast,
    output logic                  s1_tready,
    output logic [DATA_WIDTH-1:0] crc_data_in,
    output logic                  crc_data_in_valid,
    output logic                  crc_clear,
    input  logic [DATA_WIDTH-1:0] crc_data_out,
    input  logic                  crc_frame_ready,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    output logic                  m_tlast,
    output logic                  m_tid,
    input  logic                  m_tready,
    output logic                  err_trunc,
    output logic                  err_timeout
);
    localparam int CW = $clog2(MAX_WORDS + 1);

    typedef enum logic [2:0] {IDLE, CLEAR, PASS, WAIT_CRC, SEND_CRC} state_t;

    state_t                state, state_nx;
    logic                  grant, grant_nx;
    logic                  ptr, ptr_nx;
    logic [CW-1:0]         beat_cnt, beat_cnt_nx;
    logic [DATA_WIDTH-1:0] crc_hold, crc_hold_nx;

    logic                  sel_valid, sel_last, beat, last_beat;
    logic [DATA_WIDTH-1:0] sel_data;

    logic                  s0_ready_c, s1_ready_c, m_tvalid_c, m_tlast_c, m_tid_c;
    logic                  crc_clear_c, crc_valid_c, err_trunc_c;
    logic [DATA_WIDTH-1:0] m_tdata_c, crc_data_c;

`ifdef CRC_FRAME_TIMEOUT_EN
    localparam int TW = $clog2(CRC_TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt, tmo_cnt_nx;
    logic          err_timeout_c;
`endif

    assign sel_valid = grant ? s1_tvalid : s0_tvalid;
    assign sel_last  = grant ? s1_tlast  : s0_tlast;
    assign sel_data  = grant ? s1_tdata  : s0_tdata;
    assign beat      = (state == PASS) && sel_valid && m_tready;
    // The MAX_WORDS-th beat closes the frame even without tlast.
    assign last_beat = beat && (sel_last || (beat_cnt == CW'(MAX_WORDS - 1)));

    always_comb begin
        state_nx    = state;
        grant_nx    = grant;
        ptr_nx      = ptr;
        beat_cnt_nx = beat_cnt;
        crc_hold_nx = crc_hold;
        s0_ready_c  = 1'b0;
        s1_ready_c  = 1'b0;
        m_tvalid_c  = 1'b0;
        m_tlast_c   = 1'b0;
        m_tid_c     = 1'b0;
        m_tdata_c   = '0;
        crc_clear_c = 1'b0;
        crc_valid_c = 1'b0;
        crc_data_c  = '0;
        err_trunc_c = 1'b0;
`ifdef CRC_FRAME_TIMEOUT_EN
        tmo_cnt_nx    = tmo_cnt;
        err_timeout_c = 1'b0;
`endif
        unique case (state)
            IDLE: begin
                if (s0_tvalid || s1_tvalid) begin
                    // Pointer only arbitrates a tie; a lone requester always wins.
                    grant_nx = (s0_tvalid && s1_tvalid) ? ptr : s1_tvalid;
                    state_nx = CLEAR;
                end
            end
            CLEAR: begin
                crc_clear_c = 1'b1;
                beat_cnt_nx = '0;
                state_nx    = PASS;
            end
            PASS: begin
                s0_ready_c  = !grant && m_tready;
                s1_ready_c  = grant && m_tready;
                m_tvalid_c  = sel_valid;
                m_tdata_c   = sel_data;
                m_tid_c     = grant;
                crc_data_c  = sel_data;
                crc_valid_c = beat;
`ifdef CRC_FRAME_TIMEOUT_EN
                tmo_cnt_nx  = '0;
`endif
                if (beat) beat_cnt_nx = beat_cnt + 1'b1;
                if (last_beat) begin
                    err_trunc_c = !sel_last;
                    state_nx    = WAIT_CRC;
                end
            end
            WAIT_CRC: begin
                if (crc_frame_ready) begin
                    crc_hold_nx = crc_data_out;
                    state_nx    = SEND_CRC;
                end
`ifdef CRC_FRAME_TIMEOUT_EN
                else if (tmo_cnt == TW'(CRC_TIMEOUT - 1)) begin
                    err_timeout_c = 1'b1;
                    crc_hold_nx   = '1;
                    state_nx      = SEND_CRC;
                end else begin
                    tmo_cnt_nx = tmo_cnt + 1'b1;
                end
`endif
            end
            SEND_CRC: begin
                m_tvalid_c = 1'b1;
                m_tdata_c  = crc_hold;
                m_tlast_c  = 1'b1;
                m_tid_c    = grant;
                if (m_tready) begin
                    ptr_nx   = !grant;
                    state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge axis_aclk) begin
        if (!axis_aresetn) begin
            state    <= IDLE;
            grant    <= 1'b0;
            ptr      <= 1'b0;
            beat_cnt <= '0;
            crc_hold <= '0;
`ifdef CRC_FRAME_TIMEOUT_EN
            tmo_cnt  <= '0;
`endif
        end else begin
            state    <= state_nx;
            grant    <= grant_nx;
            ptr      <= ptr_nx;
            beat_cnt <= beat_cnt_nx;
            crc_hold <= crc_hold_nx;
`ifdef CRC_FRAME_TIMEOUT_EN
            tmo_cnt  <= tmo_cnt_nx;
`endif
        end
    end

    // Outputs are held at zero for as long as reset is asserted, not just after the edge.
    assign s0_tready         = axis_aresetn && s0_ready_c;
    assign s1_tready         = axis_aresetn && s1_ready_c;
    assign m_tvalid          = axis_aresetn && m_tvalid_c;
    assign m_tlast           = axis_aresetn && m_tlast_c;
    assign m_tid             = axis_aresetn && m_tid_c;
    assign m_tdata           = axis_aresetn ? m_tdata_c : '0;
    assign crc_clear         = axis_aresetn && crc_clear_c;
    assign crc_data_in_valid = axis_aresetn && crc_valid_c;
    assign crc_data_in       = axis_aresetn ? crc_data_c : '0;
    assign err_trunc         = axis_aresetn && err_trunc_c;
`ifdef CRC_FRAME_TIMEOUT_EN
    assign err_timeout       = axis_aresetn && err_timeout_c;
`else
    assign err_timeout       = 1'b0;
`endif

endmodule

// File: tb/tb_crc_frame_scheduler.sv
// Bench for crc_frame_scheduler: source drivers, CRC engine model, scoreboarded m stream,
// plus a second instance with MAX_WORDS=4 for truncation.
module tb_crc_frame_scheduler;
    localparam int DW      = 32;
    localparam int CRC_LAT = 2;

    typedef struct { logic [31:0] d; bit last; } beat_t;
    typedef struct { logic [31:0] d; bit last; bit tid; bit trunc; } exp_t;
    typedef struct { int id; int len; logic [31:0] base; bit exp_tid; } vec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic [DW-1:0] src_data [2];
    logic          src_valid [2];
    logic          src_last [2];
    logic          src_ready [2];
    logic [DW-1:0] crc_data_in, crc_data_out, m_tdata;
    logic          crc_data_in_valid, crc_clear, crc_frame_ready;
    logic          m_tvalid, m_tlast, m_tid, m_tready, err_trunc, err_timeout;

    crc_frame_scheduler #(.DATA_WIDTH(DW), .MAX_WORDS(256), .CRC_TIMEOUT(16)) dut (
        .axis_aclk(clk), .axis_aresetn(rst_n),
        .s0_tdata(src_data[0]), .s0_tvalid(src_valid[0]), .s0_tlast(src_last[0]), .s0_tready(src_ready[0]),
        .s1_tdata(src_data[1]), .s1_tvalid(src_valid[1]), .s1_tlast(src_last[1]), .s1_tready(src_ready[1]),
        .crc_data_in(crc_data_in), .crc_data_in_valid(crc_data_in_valid), .crc_clear(crc_clear),
        .crc_data_out(crc_data_out), .crc_frame_ready(crc_frame_ready),
        .m_tdata(m_tdata), .m_tvalid(m_tvalid), .m_tlast(m_tlast), .m_tid(m_tid), .m_tready(m_tready),
        .err_trunc(err_trunc), .err_timeout(err_timeout));

    // Truncation instance
    logic [DW-1:0] t_s1_tdata, t_crc_data_in, t_m_tdata;
    logic          t_s1_tvalid, t_s1_tlast, t_s0_tready, t_s1_tready, t_crc_data_in_valid, t_crc_clear;
    logic          t_m_tvalid, t_m_tlast, t_m_tid, t_err_trunc, t_err_timeout;

    crc_frame_scheduler #(.DATA_WIDTH(DW), .MAX_WORDS(4), .CRC_TIMEOUT(16)) dut_t (
        .axis_aclk(clk), .axis_aresetn(rst_n),
        .s0_tdata(32'd0), .s0_tvalid(1'b0), .s0_tlast(1'b0), .s0_tready(t_s0_tready),
        .s1_tdata(t_s1_tdata), .s1_tvalid(t_s1_tvalid), .s1_tlast(t_s1_tlast), .s1_tready(t_s1_tready),
        .crc_data_in(t_crc_data_in), .crc_data_in_valid(t_crc_data_in_valid), .crc_clear(t_crc_clear),
        .crc_data_out(32'h00C0FFEE), .crc_frame_ready(1'b1),
        .m_tdata(t_m_tdata), .m_tvalid(t_m_tvalid), .m_tlast(t_m_tlast), .m_tid(t_m_tid), .m_tready(1'b1),
        .err_trunc(t_err_trunc), .err_timeout(t_err_timeout));

    int checks = 0;
    int errors = 0;
    beat_t q0[$], q1[$];
    exp_t exp_q[$], t_exp_q[$];
    logic [31:0] frame_w[$];
    bit engine_en = 1'b1, fixed_en = 1'b0, tog_en = 1'b0;
    logic [31:0] fixed_val = '0, acc = '0;
    int cd = 0, cycle = 0, din_cnt = 0, clr_cnt = 0, tmo_pulses = 0, last_din_cyc = 0, tmo_lat = 0;
    int t_din_cnt = 0, t_clr_cnt = 0, t_trunc_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rotx(input logic [31:0] a, input logic [31:0] w);
        return {a[30:0], a[31]} ^ w;
    endfunction

    function automatic logic [31:0] outs();
        return {21'd0, m_tvalid, m_tlast, m_tid, src_ready[0], src_ready[1], crc_clear,
                crc_data_in_valid, err_trunc, err_timeout, |m_tdata, |crc_data_in};
    endfunction

    function automatic int q_size(input int id);
        return (id == 0) ? q0.size() : q1.size();
    endfunction

    // Source driver: present head of queue, pop when the handshake is seen.
    task automatic src_proc(input int id);
        beat_t b;
        forever begin
            if (q_size(id) == 0) src_valid[id] = 1'b0;
            else begin
                b = (id == 0) ? q0[0] : q1[0];
                src_valid[id] = 1'b1;
                src_data[id]  = b.d;
                src_last[id]  = b.last;
            end
            @(negedge clk);
            if (src_valid[id] && src_ready[id] && q_size(id) > 0) begin
                if (id == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin src_valid[0] = 0; src_data[0] = '0; src_last[0] = 0; #1; src_proc(0); end
    initial begin src_valid[1] = 0; src_data[1] = '0; src_last[1] = 0; #1; src_proc(1); end

    // m_tready: 1 normally, 1,0,0,1 pattern when tog_en.
    initial begin
        int k;
        bit [3:0] pat;
        pat = 4'b1001;
        k = 0;
        m_tready = 1'b1;
        forever begin
            @(posedge clk); #1;
            if (tog_en) begin m_tready = pat[k % 4]; k++; end
            else begin m_tready = 1'b1; k = 0; end
        end
    end

    // CRC engine model: rotate-xor over fed words, result CRC_LAT cycles after the last word.
    initial begin
        crc_frame_ready = 1'b0;
        crc_data_out    = '0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin acc = '0; cd = 0; end
            else begin
                if (crc_clear) acc = '0;
                if (crc_data_in_valid) begin
                    acc = rotx(acc, crc_data_in);
                    if ((src_valid[0] && src_ready[0] && src_last[0]) ||
                        (src_valid[1] && src_ready[1] && src_last[1])) cd = CRC_LAT;
                end
            end
            @(posedge clk); #1;
            crc_frame_ready = 1'b0;
            if (cd > 0) begin
                cd--;
                if (cd == 0 && engine_en) begin
                    crc_frame_ready = 1'b1;
                    crc_data_out    = fixed_en ? fixed_val : acc;
                end
            end
        end
    end

    // Main monitor: scoreboard pop on every m handshake, hold-stability under backpressure.
    initial begin
        exp_t e;
        bit stall;
        logic [33:0] held;
        stall = 1'b0;
        held  = '0;
        forever begin
            @(negedge clk);
            cycle++;
            if (!rst_n) stall = 1'b0;
            else begin
                if (stall && m_tvalid) chk("hold_stable", {30'd0, m_tlast, m_tid} ^ 32'(held[33:32]) ^ 32'(m_tdata != held[31:0]), 32'(held[33:32]) ^ 32'(held[33:32]));
                if (m_tvalid && m_tready) begin
                    if (exp_q.size() == 0) chk("unexpected_beat", m_tdata, 32'hDEADDEAD);
                    else begin
                        e = exp_q.pop_front();
                        chk("m_tdata", m_tdata, e.d);
                        chk("m_tlast_tid_trunc", {29'd0, m_tlast, m_tid, err_trunc}, {29'd0, e.last, e.tid, e.trunc});
                    end
                end
                stall = m_tvalid && !m_tready;
                held  = {m_tlast, m_tid, m_tdata};
                if (crc_clear) clr_cnt++;
                if (crc_data_in_valid) begin din_cnt++; last_din_cyc = cycle; end
                if (err_timeout) begin tmo_pulses++; tmo_lat = cycle - last_din_cyc; end
            end
        end
    end

    // Truncation-instance monitor.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (t_m_tvalid) begin
                    if (t_exp_q.size() == 0) chk("t_unexpected_beat", t_m_tdata, 32'hDEADDEAD);
                    else begin
                        e = t_exp_q.pop_front();
                        chk("t_m_tdata", t_m_tdata, e.d);
                        chk("t_last_tid_trunc", {29'd0, t_m_tlast, t_m_tid, t_err_trunc}, {29'd0, e.last, e.tid, e.trunc});
                    end
                end
                if (t_crc_clear) t_clr_cnt++;
                if (t_crc_data_in_valid) t_din_cnt++;
                if (t_err_trunc) t_trunc_cnt++;
            end
        end
    end

    task automatic queue_frame(input int id, input bit tid, input bit use_fixed, input logic [31:0] fval);
        logic [31:0] m;
        beat_t b;
        m = '0;
        foreach (frame_w[i]) begin
            b.d = frame_w[i];
            b.last = (i == frame_w.size() - 1);
            if (id == 0) q0.push_back(b); else q1.push_back(b);
            exp_q.push_back('{frame_w[i], 1'b0, tid, 1'b0});
            m = rotx(m, frame_w[i]);
        end
        exp_q.push_back('{use_fixed ? fval : m, 1'b1, tid, 1'b0});
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || q0.size() != 0 || q1.size() != 0) && n < 3000) begin
            @(posedge clk); #1;
            n++;
        end
        chk(name, exp_q.size(), 0);
        repeat (3) begin @(posedge clk); #1; end
    endtask

    task automatic do_reset(input int cyc);
        rst_n = 1'b0;
        q0.delete();
        q1.delete();
        repeat (cyc) begin @(negedge clk); chk("outputs_in_reset", outs(), 0); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("outputs_idle_after_reset", outs(), 0);
        @(posedge clk); #1;
    endtask

    initial begin
        vec_t vt[5];
        int d0, c0, n;
        vt[0] = '{1, 3, 32'h1111_0000, 1'b1};
        vt[1] = '{1, 2, 32'h2222_0000, 1'b1};
        vt[2] = '{0, 1, 32'h3333_0000, 1'b0};
        vt[3] = '{0, 4, 32'h4444_0000, 1'b0};
        vt[4] = '{1, 7, 32'h5555_0000, 1'b1};
        t_s1_tvalid = 1'b0; t_s1_tdata = '0; t_s1_tlast = 1'b0;
        rst_n = 1'b0;
        #1;
        do_reset(3);

        // Reference frame with a fixed engine result
        fixed_en = 1'b1; fixed_val = 32'hCBF43926;
        d0 = din_cnt; c0 = clr_cnt;
        frame_w = '{32'd5, 32'd3, 32'd678, 32'd76, 32'd89};
        queue_frame(0, 1'b0, 1'b1, 32'hCBF43926);
        wait_drain("ref_frame_drain");
        chk("ref_din_count", din_cnt - d0, 5);
        chk("ref_clear_count", clr_cnt - c0, 1);
        fixed_en = 1'b0;

        // Single-requester frames from the table
        for (int v = 0; v < 5; v++) begin
            d0 = din_cnt; c0 = clr_cnt;
            frame_w.delete();
            for (int i = 0; i < vt[v].len; i++) frame_w.push_back(vt[v].base ^ (i * 32'h9E3779B9));
            queue_frame(vt[v].id, vt[v].exp_tid, 1'b0, '0);
            wait_drain("table_drain");
            chk("table_din_count", din_cnt - d0, vt[v].len);
            chk("table_clear_count", clr_cnt - c0, 1);
        end

        // Both requesters continuously valid: grants must alternate s0,s1,s0,s1
        do_reset(1);
        for (int f = 0; f < 4; f++) begin
            frame_w = '{32'hA000_0000 + f * 16, 32'hA000_0001 + f * 16};
            queue_frame(f % 2, 1'(f % 2), 1'b0, '0);
        end
        wait_drain("alternate_drain");

        // Backpressure on m_tready
        tog_en = 1'b1;
        d0 = din_cnt;
        frame_w = '{32'h10, 32'h20, 32'h30, 32'h40, 32'h50};
        queue_frame(0, 1'b0, 1'b0, '0);
        wait_drain("backpressure_drain");
        chk("backpressure_din_count", din_cnt - d0, 5);
        tog_en = 1'b0;

        // Reset after word 3 of a 5-word frame: no CRC may follow
        d0 = din_cnt; c0 = clr_cnt;
        for (int i = 0; i < 5; i++) q0.push_back('{32'h7000 + i, i == 4});
        for (int i = 0; i < 3; i++) exp_q.push_back('{32'h7000 + i, 1'b0, 1'b0, 1'b0});
        n = 0;
        while (din_cnt - d0 < 3 && n < 200) begin @(posedge clk); #1; n++; end
        chk("midreset_words_before", din_cnt - d0, 3);
        rst_n = 1'b0;
        q0.delete();
        @(negedge clk);
        chk("midreset_outputs", outs(), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (8) begin @(negedge clk); chk("midreset_idle", outs(), 0); end
        chk("midreset_clear_count", clr_cnt - c0, 1);
        @(posedge clk); #1;
        frame_w = '{32'h8000, 32'h8001, 32'h8002};
        queue_frame(0, 1'b0, 1'b0, '0);
        wait_drain("post_reset_drain");

`ifdef CRC_FRAME_TIMEOUT_EN
        engine_en = 1'b0;
        frame_w = '{32'h9000, 32'h9001};
        queue_frame(1, 1'b1, 1'b1, 32'hFFFF_FFFF);
        wait_drain("timeout_drain");
        chk("timeout_pulses", tmo_pulses, 1);
        chk("timeout_latency", tmo_lat, 16);
        engine_en = 1'b1;
`else
        chk("timeout_pulses", tmo_pulses, 0);
`endif

        // Truncation on the MAX_WORDS=4 instance
        for (int i = 0; i < 6; i++) begin
            t_exp_q.push_back('{32'(i + 1), 1'b0, 1'b1, i == 3});
            if (i == 3 || i == 5) t_exp_q.push_back('{32'h00C0FFEE, 1'b1, 1'b1, 1'b0});
        end
        for (int i = 0; i < 6; i++) begin
            t_s1_tvalid = 1'b1; t_s1_tdata = 32'(i + 1); t_s1_tlast = (i == 5);
            n = 0;
            do begin @(negedge clk); n++; end while (!t_s1_tready && n < 50);
            chk("t_accept", {31'd0, t_s1_tready}, 1);
            @(posedge clk); #1;
        end
        t_s1_tvalid = 1'b0; t_s1_tlast = 1'b0;
        n = 0;
        while (t_exp_q.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
        chk("t_drain", t_exp_q.size(), 0);
        chk("t_din_count", t_din_cnt, 6);
        chk("t_clear_count", t_clr_cnt, 2);
        chk("t_trunc_count", t_trunc_cnt, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time (errors so far %0d)", errors);
        $fatal(1);
    end

endmodule

// File: doc/crc_frame_scheduler.md
CRC_FRAME_SCHEDULER -- requirements
Module: crc_frame_scheduler

Interface
Parameters (name, default, meaning):
REQ-001 The block SHALL have parameter DATA_WIDTH, default 32, giving the word width of all data ports.
REQ-002 The block SHALL have parameter MAX_WORDS, default 256, giving the maximum payload words per frame.
REQ-003 The block SHALL have parameter CRC_TIMEOUT, default 16, giving the WAIT_CRC timeout in cycles.

Ports (name, direction, width, meaning):
REQ-004 axis_aclk  in  1  single clock; all logic on its rising edge.
REQ-005 axis_aresetn  in  1  reset, synchronous, active-low.
REQ-006 s0_tdata/s0_tvalid/s0_tlast  in  DATA_WIDTH/1/1  requester 0 stream; s0_tready  out  1.
REQ-007 s1_tdata/s1_tvalid/s1_tlast  in  DATA_WIDTH/1/1  requester 1 stream; s1_tready  out  1.
REQ-008 crc_data_in  out  DATA_WIDTH  word to shared CRC engine; crc_data_in_valid  out  1  word strobe; crc_clear  out  1  engine restart pulse.
REQ-009 crc_data_out  in  DATA_WIDTH  engine result; crc_frame_ready  in  1  result valid.
REQ-010 m_tdata  out  DATA_WIDTH; m_tvalid  out  1; m_tlast  out  1; m_tid  out  1  granted requester; m_tready  in  1.
REQ-011 err_trunc  out  1  one-cycle pulse on truncation; err_timeout  out  1  one-cycle pulse on CRC timeout.

Function
REQ-012 FSM states SHALL be IDLE, CLEAR, PASS, WAIT_CRC, SEND_CRC.
REQ-013 IDLE: when any s*_tvalid is high, grant by round-robin (pointer favours the requester not served last), go to CLEAR.
REQ-014 Simultaneous requests SHALL be granted alternately; a lone requester SHALL be granted regardless of pointer.
REQ-015 CLEAR: crc_clear high for exactly one cycle, all tready low; next state PASS.
REQ-016 PASS: granted s_tready = m_tready; other s_tready = 0; m_tvalid = granted s_tvalid; m_tdata = granted s_tdata; m_tid = grant; m_tlast = 0.
REQ-017 On each PASS beat (s_tvalid & m_tready) crc_data_in SHALL carry that word with crc_data_in_valid high the same cycle.
REQ-018 A beat with s_tlast=1 SHALL move to WAIT_CRC.
REQ-019 Beat counter SHALL count payload beats; the MAX_WORDS-th beat without tlast SHALL be treated as last, pulse err_trunc, go WAIT_CRC; subsequent source words start a new frame.
REQ-020 WAIT_CRC: all tready low, m_tvalid low; on crc_frame_ready=1 latch crc_data_out and go SEND_CRC.
REQ-021 SEND_CRC: m_tvalid=1, m_tdata=latched CRC, m_tlast=1, m_tid=grant; on m_tready go IDLE and set pointer away from grant.
REQ-022 m_tdata/m_tid/m_tlast SHALL remain stable while m_tvalid=1 and m_tready=0.
REQ-023 Next frame SHALL NOT start before the SEND_CRC handshake completes (minimum one IDLE cycle between frames).

Reset
REQ-024 axis_aresetn=0 at a clock edge SHALL force IDLE, pointer to requester 0, counters 0, latched CRC 0.
REQ-025 During and after reset all outputs SHALL be 0 until the FSM drives them.
REQ-026 Reset mid-frame SHALL abandon the frame with no CRC word emitted.

Configuration
REQ-027 Macro CRC_FRAME_TIMEOUT_EN defined: WAIT_CRC counts cycles; at CRC_TIMEOUT cycles without crc_frame_ready, pulse err_timeout, latch 0xFFFFFFFF (all ones) and go SEND_CRC.
REQ-028 Macro CRC_FRAME_TIMEOUT_EN undefined: WAIT_CRC waits indefinitely; err_timeout tied 0.

Verification
REQ-029 s0 sends 5,3,678,76,89 (tlast on 89), m_tready=1, engine returns 0xCBF43926 two cycles later -> m stream 5,3,678,76,89,0xCBF43926, m_tlast only on CRC word, m_tid=0, one crc_clear pulse before word 5.
REQ-030 s0 and s1 both valid continuously with 2-word frames -> grants s0,s1,s0,s1; no interleaving of words within a frame.
REQ-031 m_tready toggled 1,0,0,1 during PASS and SEND_CRC -> no word lost/duplicated; crc_data_in_valid count equals payload beat count.
REQ-032 MAX_WORDS=4, s1 sends 6 words, tlast on 6th -> frame1 = 4 words + CRC with err_trunc pulse on 4th beat; frame2 = 2 words + CRC.
REQ-033 axis_aresetn low for one cycle after word 3 of a 5-word frame -> all outputs 0, FSM IDLE, no CRC emitted; next frame correct.
REQ-034 CRC_FRAME_TIMEOUT_EN defined, crc_frame_ready held 0 -> err_timeout pulse after 16 cycles, CRC word 0xFFFFFFFF with m_tlast=1.
